// File: rtl/iter_multiply_if.sv
// Start/done handshake and operand/result bus of the iterative multiplier.
interface iter_multiply_if #(
    parameter int WIDTH = 32
);
    logic                 mult_begin;
    logic                 mult_signed;
    logic [WIDTH-1:0]     mult_op1;
    logic [WIDTH-1:0]     mult_op2;
    logic                 mult_cancel;
    logic                 mult_ready;
    logic                 busy;
    logic                 mult_end;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output mult_begin, mult_signed, mult_op1, mult_op2, mult_cancel,
        input  mult_ready, busy, mult_end, product
    );

    modport slave (
        input  mult_begin, mult_signed, mult_op1, mult_op2, mult_cancel,
        output mult_ready, busy, mult_end, product
    );
endinterface

// File: rtl/iter_multiply.sv
// Multi-cycle shift-add multiplier: one multiplier bit per cycle, full 2*WIDTH
// product, signed/unsigned, cancellable by the pipeline while calculating.
module iter_multiply #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    iter_multiply_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mcand, acc, acc_sum, product_q;
    logic [WIDTH-1:0]     mplier, mag1, mag2;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic                 accept, last;

    assign accept = ((state == IDLE) || (state == DONE)) && bus.mult_begin;
    assign last   = (state == CALC) && !bus.mult_cancel && (cnt == LAST_CNT);

    // The most-negative value negates to its own bit pattern, which is already
    // the correct unsigned magnitude.
    assign mag1 = (bus.mult_signed && bus.mult_op1[WIDTH-1]) ? (~bus.mult_op1 + WIDTH'(1)) : bus.mult_op1;
    assign mag2 = (bus.mult_signed && bus.mult_op2[WIDTH-1]) ? (~bus.mult_op2 + WIDTH'(1)) : bus.mult_op2;

    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.mult_begin) state_nxt = CALC;
            CALC: begin
                if (bus.mult_cancel)        state_nxt = IDLE;
                else if (cnt == LAST_CNT)   state_nxt = DONE;
            end
            DONE: state_nxt = bus.mult_begin ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplicand is kept 2*WIDTH wide and shifted, so the running sum never
    // needs a variable shift by the counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            product_q <= '0;
        end else begin
            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, mag1};
                mplier <= mag2;
                acc    <= '0;
                cnt    <= '0;
                neg    <= bus.mult_signed & (bus.mult_op1[WIDTH-1] ^ bus.mult_op2[WIDTH-1]);
            end else if (state == CALC) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
            end
            if (last) product_q <= neg ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
        end
    end

    assign bus.mult_ready = (state == IDLE) || (state == DONE);
    assign bus.busy       = (state == CALC);
    assign bus.mult_end   = (state == DONE);
    assign bus.product    = product_q;
endmodule

// File: doc/iter_multiply.md
Name: iter_multiply

Overview:
- Parametrised, multi-cycle shift-add multiplier for the MIPS execute stage. Successor to the single-cycle 32-bit signed multiplier.
- Returns the full 2*WIDTH-bit product for MULT/MULTU, so the HI and LO halves are both available.
- Supports signed and unsigned modes, uses a start/done handshake, and can be cancelled by the pipeline on an exception or flush.
- Retires one multiplier bit per cycle.

Parameters:
- WIDTH, 32, operand width in bits. Must be at least 2. The product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- mult_begin  input  1  start request. Accepted only when mult_ready=1.
- mult_signed  input  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU). Sampled with mult_begin.
- mult_op1  input  WIDTH  multiplicand. Sampled on accept.
- mult_op2  input  WIDTH  multiplier. Sampled on accept.
- mult_cancel  input  1  abort the in-flight operation (exception/flush).
- mult_ready  output  1  1 in IDLE or DONE.
- busy  output  1  1 in CALC.
- mult_end  output  1  one-cycle completion pulse.
- product  output  2*WIDTH  result register. {HI,LO} = product[2W-1:W], product[W-1:0].

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, product=0, mult_end=0, busy=0, mult_ready=1.
  - Internal counter, accumulator, magnitudes and sign flag are all cleared.
- States and transitions:
  - IDLE: on mult_begin=1, go to CALC. Otherwise stay in IDLE.
  - CALC: on mult_cancel=1, go to IDLE. Otherwise, when the counter reaches WIDTH-1, go to DONE on that edge. Otherwise stay in CALC.
  - DONE: mult_end=1 for exactly this cycle. On mult_begin=1, go to CALC (back-to-back start). Otherwise go to IDLE.
- Accept edge (IDLE or DONE with mult_begin=1):
  - Capture a1 = |op1| and a2 = |op2| as WIDTH-bit unsigned magnitudes when mult_signed=1 and the MSB is set. Otherwise capture the raw operands.
  - The magnitude of the most-negative value equals its raw bit pattern. This is correct as an unsigned magnitude.
  - Sign flag = mult_signed & (op1[W-1] ^ op2[W-1]).
  - Accumulator=0, counter=0.
- CALC iteration (one per cycle):
  - If a2[0]=1, add a1 shifted left by counter into the 2W-bit accumulator.
  - Then shift a2 right by 1 and increment the counter.
  - Equivalent formulations are allowed (e.g. shifting a 2W-bit multiplicand). Accumulator width is 2W bits and the sum never overflows.
- Edge entering DONE:
  - product <= sign ? (~acc_final + 1) : acc_final, where acc_final includes the last partial product.
  - product changes only on this edge and on reset. It holds its value through IDLE, later CALC, and cancels.
- Latency:
  - Accept edge at cycle 0. mult_end=1 during cycle WIDTH+1 (33 for WIDTH=32). product is valid in that same cycle.
  - Throughput with back-to-back begin: one result per WIDTH+1 cycles.
- Ignored inputs:
  - mult_begin in CALC is ignored. It is not queued.
  - Operand and mode changes after accept have no effect.
- Cancel:
  - mult_cancel in CALC forces IDLE on the next edge. No mult_end is produced and product is unchanged.
  - mult_cancel in IDLE or DONE is ignored. A simultaneous mult_begin in DONE is still accepted, so cancel does not block a fresh begin.
  - mult_cancel and mult_begin together in IDLE: the begin is accepted.
- Mid-operation reset: reset in any state immediately returns all outputs to their reset values.
- Unsigned mode: no sign correction. The full 2W-bit product equals op1*op2.
- Signed mode: the result equals the 2W-bit two's-complement product.

Test Plan:
- Reset during CALC (cycle 10):
  - busy, mult_end and product go to 0 immediately.
  - After release, a new begin with 7*6 unsigned yields product=0x00000000_0000002A at cycle 33.
- Signed, op1=0xFFFFFFFD (-3), op2=0x00000005 -> mult_end at cycle 33, product=0xFFFFFFFF_FFFFFFF1. busy=1 for cycles 1..32.
- Unsigned, 0xFFFFFFFF*0xFFFFFFFF -> product=0xFFFFFFFE_00000001.
- Same operands in signed mode -> product=0x00000000_00000001.
- Signed 0x80000000*0x80000000 -> 0x40000000_00000000.
- Signed 0x80000000*0x00000001 -> 0xFFFFFFFF_80000000.
- Zero operand, signed 0*0xFFFFFFFF -> 0x0.
- Cancel in CALC at cycle 5:
  - IDLE at the next edge, no mult_end pulse, product retains the previous value.
  - mult_begin asserted during CALC is ignored: no second mult_end appears.
- Back-to-back: mult_begin held high through DONE with new operands 3*4 unsigned.
  - First mult_end at cycle 33, second at cycle 66 with product=0xC.
  - mult_ready=1 only in cycles 0, 33 and 66.
- WIDTH=8 instance, random signed/unsigned pairs (including 0x80 and 0xFF), checked against a reference model:
  - mult_end at cycle 9.
  - The 16-bit product matches the model for all 65536×2 combinations.
